multi_core_mem_arbiter: RTL and testbench

MULTI_CORE_MEM_ARBITER -- requirements
Module: multi_core_mem_arbiter

---
 rtl/multi_core_mem_arbiter_if.sv | 42 ++++
 rtl/multi_core_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_multi_core_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_core_mem_arbiter_if.sv
// Bus bundle between the cores, the arbiter and the shared memory.
// The arbiter connects through the slave modport. The master modport is the
// mirror view, used by whatever drives the cores and the memory.
`timescale 1ns/1ps

interface multi_core_mem_arbiter_if #(
  parameter int NUM_CORES  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Core side.
  logic [NUM_CORES-1:0]            core_req;
  logic [NUM_CORES-1:0]            core_we;
  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr;
  logic [NUM_CORES*DATA_WIDTH-1:0] core_wdata;
  logic [NUM_CORES-1:0]            core_ack;
  logic [DATA_WIDTH-1:0]           core_rdata;

  // Shared-memory side.
  logic                            mem_en;
  logic                            mem_we;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic [DATA_WIDTH-1:0]           mem_rdata;

  // Status.
  logic                            busy;
  logic [2:0]                      grant_idx;
  logic [31:0]                     txn_count;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, mem_rdata,
    output core_ack, core_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           busy, grant_idx, txn_count
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, mem_rdata,
    input  core_ack, core_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           busy, grant_idx, txn_count
  );
endinterface

// File: rtl/multi_core_mem_arbiter.sv
// Round-robin arbiter that lets NUM_CORES cores share one memory port.
// Each grant runs a fixed sequence: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Every output is registered. The last-granted core gets the lowest priority
// at the next arbitration.
`timescale 1ns/1ps

module multi_core_mem_arbiter #(
  parameter int NUM_CORES   = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  multi_core_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state_q;
  logic [2:0]             grant_q;
  logic [2:0]             lat_q;
  logic [NUM_CORES-1:0]   ack_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   mem_en_q;
  logic                   mem_we_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [DATA_WIDTH-1:0]  mem_wdata_q;
  logic                   busy_q;
  logic [31:0]            txn_q;

  // Arbitration result and the winner's request fields.
  logic [2:0]             grant_d;
  logic                   grant_valid_d;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic                   sel_we;
  logic [2*NUM_CORES-1:0] req_dbl;
  logic [NUM_CORES-1:0]   req_rot;
  logic [3:0]             base;
  logic [3:0]             cand;

  // Rotate requests so that bit 0 is the core after the last grant, then take the lowest set bit.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment, so no latch is inferred.
    grant_d       = grant_q;
    grant_valid_d = |bus.core_req;
    sel_addr      = '0;
    sel_wdata     = '0;
    sel_we        = 1'b0;
    cand          = '0;
    base          = {1'b0, grant_q} + 4'd1;
    req_dbl       = {bus.core_req, bus.core_req};
    req_rot       = NUM_CORES'(req_dbl >> base);
    // Scan downward so that the closest requester is the last one written and wins.
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        cand = base + 4'(k);
        if (cand >= 4'(NUM_CORES)) begin
          cand = cand - 4'(NUM_CORES);
        end
        grant_d = cand[2:0];
      end
    end
    for (int k = 0; k < NUM_CORES; k++) begin
      if (grant_d == 3'(k)) begin
        sel_addr  = bus.core_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.core_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        sel_we    = bus.core_we[k];
      end
    end
  end

  // Transaction FSM and all of its registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments, so every register samples pre-edge values.
    if (!reset) begin
      state_q     <= IDLE;
      grant_q     <= 3'(NUM_CORES - 1);
      lat_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      txn_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Latch the winner's request into the memory-side registers. Later changes on the core side have no effect.
          if (grant_valid_d) begin
            grant_q     <= grant_d;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_we_q    <= sel_we;
            mem_en_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          // The strobe is high for exactly one cycle. Address and write data keep their values.
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          lat_q    <= 3'(MEM_LATENCY);
          state_q  <= WAIT;
        end
        WAIT: begin
          if (lat_q == 3'd1) begin
            rdata_q <= bus.mem_rdata;
            ack_q   <= {{(NUM_CORES-1){1'b0}}, 1'b1} << grant_q;
            txn_q   <= txn_q + 32'd1;
            state_q <= RESP;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        RESP: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.core_ack   = ack_q;
  assign bus.core_rdata = rdata_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.busy       = busy_q;
  assign bus.grant_idx  = grant_q;
  assign bus.txn_count  = txn_q;

endmodule

// File: tb/tb_multi_core_mem_arbiter.sv
// Directed bench for multi_core_mem_arbiter across three configurations:
//   A: 2 cores, latency 1   B: 2 cores, latency 3   C: 4 cores, latency 1
// When a request is driven, the expected acks go into a scoreboard queue.
// Each ack pops one entry and is compared against it.
`timescale 1ns/1ps

module tb_multi_core_mem_arbiter;

  localparam logic [31:0] BAD = 32'hBAD0_0BAD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b, reset_c;

  multi_core_mem_arbiter_if #(.NUM_CORES(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) if_a ();
  multi_core_mem_arbiter_if #(.NUM_CORES(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) if_b ();
  multi_core_mem_arbiter_if #(.NUM_CORES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) if_c ();

  multi_core_mem_arbiter #(.NUM_CORES(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1))
    dut_a (.clk(clk), .reset(reset_a), .bus(if_a.slave));
  multi_core_mem_arbiter #(.NUM_CORES(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3))
    dut_b (.clk(clk), .reset(reset_b), .bus(if_b.slave));
  multi_core_mem_arbiter #(.NUM_CORES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1))
    dut_c (.clk(clk), .reset(reset_c), .bus(if_c.slave));

  typedef struct {
    int          core;
    logic [31:0] rdata;
    int          ack_cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc     = 0;
  int          men_b   = 0;
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] b_p1, b_p2;

  // Memory contents as a pure function of the address.
  function automatic logic [31:0] rd_pat(input logic [31:0] addr);
    return (addr == 32'h10) ? 32'hDEADBEEF : {~addr[15:0], addr[15:0]};
  endfunction

  // Memory models. Read data is valid exactly MEM_LATENCY cycles after mem_en; at any other time the bus carries BAD.
  always @(posedge clk) begin
    cyc            <= cyc + 1;
    if_a.mem_rdata <= (if_a.mem_en === 1'b1) ? rd_pat(if_a.mem_addr) : BAD;
    if_c.mem_rdata <= (if_c.mem_en === 1'b1) ? rd_pat(if_c.mem_addr) : BAD;
    b_p1           <= (if_b.mem_en === 1'b1) ? rd_pat(if_b.mem_addr) : BAD;
    b_p2           <= b_p1;
    if_b.mem_rdata <= b_p2;
    if (if_b.mem_en === 1'b1) men_b <= men_b + 1;
  end

  function automatic logic [63:0] ack_of(input int inst);
    case (inst)
      0:       return 64'(if_a.core_ack);
      1:       return 64'(if_b.core_ack);
      default: return 64'(if_c.core_ack);
    endcase
  endfunction

  function automatic logic [63:0] rdata_of(input int inst);
    case (inst)
      0:       return 64'(if_a.core_rdata);
      1:       return 64'(if_b.core_rdata);
      default: return 64'(if_c.core_rdata);
    endcase
  endfunction

  function automatic logic [63:0] busy_of(input int inst);
    case (inst)
      0:       return 64'(if_a.busy);
      1:       return 64'(if_b.busy);
      default: return 64'(if_c.busy);
    endcase
  endfunction

  function automatic logic [63:0] grant_of(input int inst);
    case (inst)
      0:       return 64'(if_a.grant_idx);
      1:       return 64'(if_b.grant_idx);
      default: return 64'(if_c.grant_idx);
    endcase
  endfunction

  function automatic logic [63:0] txn_of(input int inst);
    case (inst)
      0:       return 64'(if_a.txn_count);
      1:       return 64'(if_b.txn_count);
      default: return 64'(if_c.txn_count);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  // Wait (bounded) for an ack, then compare it against the oldest scoreboard entry.
  task automatic expect_ack(input int inst);
    int   n;
    exp_t e;
    n = 0;
    while (ack_of(inst) == 64'd0 && n < 20) begin
      tick();
      n++;
    end
    if (ack_of(inst) == 64'd0) begin
      n_total++;
      $error("FAIL ack_timeout: inst %0d saw no core_ack within 20 cycles, required one", inst);
    end else if (sb.size() == 0) begin
      n_total++;
      $error("FAIL unexpected_ack: inst %0d core_ack 0x%0h with no pending transaction", inst, ack_of(inst));
    end else begin
      e = sb.pop_front();
      check("ack_onehot", ack_of(inst), 64'd1 << e.core);
      check("ack_rdata", rdata_of(inst), 64'(e.rdata));
      check("ack_cycle", 64'(cyc), 64'(e.ack_cyc));
      check("ack_grant_idx", grant_of(inst), 64'(e.core));
    end
  endtask

  // The cycle after an ack: the pulse has ended and the arbiter is back in IDLE.
  task automatic post_ack(input int inst);
    tick();
    check("ack_pulse_end", ack_of(inst), 64'd0);
    check("idle_not_busy", busy_of(inst), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0;
    int   men0;
    logic seen;

    reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
    if_a.core_req = '0; if_a.core_we = '0; if_a.core_addr = '0; if_a.core_wdata = '0;
    if_b.core_req = '0; if_b.core_we = '0; if_b.core_addr = '0; if_b.core_wdata = '0;
    if_c.core_req = '0; if_c.core_we = '0; if_c.core_addr = '0; if_c.core_wdata = '0;
    repeat (3) tick();

    // Reset state.
    check("rst_ack",       64'(if_a.core_ack),   64'd0);
    check("rst_mem_en",    64'(if_a.mem_en),     64'd0);
    check("rst_mem_we",    64'(if_a.mem_we),     64'd0);
    check("rst_busy",      64'(if_a.busy),       64'd0);
    check("rst_mem_addr",  64'(if_a.mem_addr),   64'd0);
    check("rst_mem_wdata", 64'(if_a.mem_wdata),  64'd0);
    check("rst_rdata",     64'(if_a.core_rdata), 64'd0);
    check("rst_txn",       64'(if_a.txn_count),  64'd0);
    check("rst_grant_a",   64'(if_a.grant_idx),  64'd1);
    check("rst_grant_c",   64'(if_c.grant_idx),  64'd3);
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    tick();

    // A: core 0 reads 0x10 and drops its request right after the latch.
    if_a.core_addr = {32'h0, 32'h10};
    if_a.core_req  = 2'b01;
    sb.push_back('{0, 32'hDEADBEEF, cyc + 3});
    tick();
    check("a_issue_en",   64'(if_a.mem_en),   64'd1);
    check("a_issue_we",   64'(if_a.mem_we),   64'd0);
    check("a_issue_addr", 64'(if_a.mem_addr), 64'h10);
    check("a_issue_busy", 64'(if_a.busy),     64'd1);
    if_a.core_req = 2'b00;
    tick();
    check("a_mem_en_one_cycle", 64'(if_a.mem_en), 64'd0);
    expect_ack(0);
    post_ack(0);
    check("a_txn_1", txn_of(0), 64'd1);

    // A: core 1 writes. Its request fields change after the latch, and the transaction must not see the change.
    if_a.core_req          = 2'b10;
    if_a.core_we           = 2'b10;
    if_a.core_addr[63:32]  = 32'h24;
    if_a.core_wdata[63:32] = 32'h1234;
    sb.push_back('{1, rd_pat(32'h24), cyc + 3});
    tick();
    check("a_wr_we",    64'(if_a.mem_we),    64'd1);
    check("a_wr_addr",  64'(if_a.mem_addr),  64'h24);
    check("a_wr_wdata", 64'(if_a.mem_wdata), 64'h1234);
    if_a.core_req          = 2'b00;
    if_a.core_we           = 2'b00;
    if_a.core_addr[63:32]  = 32'h99;
    if_a.core_wdata[63:32] = 32'hFFFF;
    expect_ack(0);
    post_ack(0);
    check("a_hold_addr",  64'(if_a.mem_addr),  64'h24);
    check("a_hold_wdata", 64'(if_a.mem_wdata), 64'h1234);
    check("a_idle_we",    64'(if_a.mem_we),    64'd0);
    check("a_txn_2",      txn_of(0),           64'd2);

    // A: both cores request continuously. Grants alternate 0,1,0,1 and acks come 4 cycles apart.
    if_a.core_addr = {32'h80, 32'h40};
    if_a.core_req  = 2'b11;
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{k % 2, rd_pat((k % 2 == 1) ? 32'h80 : 32'h40), c0 + 3 + 4 * k});
    end
    for (int k = 0; k < 4; k++) begin
      expect_ack(0);
      if (k == 3) if_a.core_req = 2'b00;
      post_ack(0);
    end
    check("a_txn_6", txn_of(0), 64'd6);

    // B: reset asserted while the transaction is in WAIT abandons it.
    if_b.core_addr = {32'h0, 32'h30};
    if_b.core_req  = 2'b01;
    tick();
    check("b_issue_en", 64'(if_b.mem_en), 64'd1);
    if_b.core_req = 2'b00;
    tick();
    reset_b = 1'b0;
    tick();
    check("b_rst_ack",    64'(if_b.core_ack),  64'd0);
    check("b_rst_busy",   64'(if_b.busy),      64'd0);
    check("b_rst_mem_en", 64'(if_b.mem_en),    64'd0);
    check("b_rst_txn",    64'(if_b.txn_count), 64'd0);
    reset_b = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      seen = seen | (|if_b.core_ack);
    end
    check("b_no_ack_after_rst", 64'(seen), 64'd0);
    check("b_rst_grant",        grant_of(1), 64'd1);

    // B (latency 3): core 1 writes 0x55 to 0x20.
    men0 = men_b;
    if_b.core_req          = 2'b10;
    if_b.core_we           = 2'b10;
    if_b.core_addr[63:32]  = 32'h20;
    if_b.core_wdata[63:32] = 32'h55;
    sb.push_back('{1, rd_pat(32'h20), cyc + 5});
    tick();
    check("b_wr_en",    64'(if_b.mem_en),    64'd1);
    check("b_wr_we",    64'(if_b.mem_we),    64'd1);
    check("b_wr_addr",  64'(if_b.mem_addr),  64'h20);
    check("b_wr_wdata", 64'(if_b.mem_wdata), 64'h55);
    if_b.core_req = 2'b00;
    if_b.core_we  = 2'b00;
    expect_ack(1);
    post_ack(1);
    check("b_mem_en_cycles", 64'(men_b - men0), 64'd1);
    check("b_txn_1",         txn_of(1),         64'd1);

    // C: serve core 1 first (grant_idx becomes 1), then cores 1 and 3 request together: core 3 wins, then core 1.
    if_c.core_addr = {32'h300, 32'h0, 32'h100, 32'h0};
    if_c.core_req  = 4'b0010;
    sb.push_back('{1, rd_pat(32'h100), cyc + 3});
    tick();
    if_c.core_req = 4'b0000;
    expect_ack(2);
    post_ack(2);
    check("c_grant_1", grant_of(2), 64'd1);
    if_c.core_req = 4'b1010;
    c0 = cyc;
    sb.push_back('{3, rd_pat(32'h300), c0 + 3});
    sb.push_back('{1, rd_pat(32'h100), c0 + 7});
    expect_ack(2);
    post_ack(2);
    expect_ack(2);
    if_c.core_req = 4'b0000;
    post_ack(2);
    check("c_txn_3",    txn_of(2),          64'd3);
    check("sb_drained", 64'(sb.size()),     64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
